j1_inst_fetch: RTL and testbench
================================

# j1_inst_fetch

Instruction-fetch front end for a `wb_j1_cpu` core. It sits directly upstream of the CPU's external instruction port (`inst_cyc_o`/`inst_pc_o` → `inst_i`/`inst_ack_i`). It serves fetches for PCs outside the local ROM window (`pc[13:12] != 0`) from a small direct-mapped instruction cache. Misses are filled by a single-word Wishbone classic read.

## Interface

Parameters:
- `LINES`, default 16: cache lines, one 32-bit word each; power of 2, 2..256.
- `BASE_ADDR`, default 32'h0000_0000: byte address added to the fetch address on the bus.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `cpu_cyc_i` in 1: fetch request; CPU holds it and `cpu_pc_i` stable until `cpu_ack_o`.
- `cpu_pc_i` in 14 (`PcWidth`): word address of the instruction.
- `cpu_inst_o` out 32: instruction word; valid in the `cpu_ack_o` cycle and held until the next ack.
- `cpu_ack_o` out 1: one-cycle completion pulse.
- `flush_i` in 1: invalidate all lines, one-cycle pulse.
- `wb_cyc_o` out 1: Wishbone cycle.
- `wb_stb_o` out 1: Wishbone strobe, equal to `wb_cyc_o`.
- `wb_adr_o` out 32: byte address, `BASE_ADDR + {16'b0, pc, 2'b00}`.
- `wb_dat_i` in 32: read data.
- `wb_ack_i` in 1: slave acknowledge.

## Operation

- Cache layout: index = `pc[IW-1:0]`, with `IW = log2(LINES)`. Tag = `pc[13:IW]`. There is one valid bit per line.
- FSM states: IDLE, LOOKUP, FILL, RESP.
  - IDLE: if `cpu_cyc_i` is high, latch `cpu_pc_i` into `req_pc` and go to LOOKUP.
  - LOOKUP: read the line at `req_pc`.
    - Hit (valid and tag match): drive `cpu_inst_o` = line data, pulse `cpu_ack_o`, go to IDLE.
    - Miss: go to FILL.
  - FILL: assert `wb_cyc_o`/`wb_stb_o`, with `wb_adr_o` from `req_pc` (held stable). On `wb_ack_i`:
    - write the line (data, tag, valid=1);
    - register the data into `cpu_inst_o`;
    - go to RESP.
  - RESP: pulse `cpu_ack_o`, go to IDLE.
- `cpu_inst_o` comes from an output register. It is updated only on a hit in LOOKUP or on `wb_ack_i` in FILL.
- Flush:
  - `flush_i` clears every valid bit at the next edge.
  - If `flush_i` coincides with a fill write, the flush wins: the line stays invalid, but the CPU still receives the fetched word and ack.
  - A flush in the same cycle as a LOOKUP does not affect that lookup's hit/miss result.
- `cpu_cyc_i` dropping before ack is a CPU protocol violation. The block completes the transaction regardless.
- A request arriving in the cycle after an ack is a new request and is accepted in IDLE.
- Reset values:
  - state = IDLE; all valid bits = 0;
  - `cpu_inst_o` = 32'h6000_0000 (ALU no-op);
  - `cpu_ack_o` = 0; `wb_cyc_o` = `wb_stb_o` = 0; `wb_adr_o` = `BASE_ADDR`.
- Reset mid-FILL drops `wb_cyc_o` at the next edge. Any later `wb_ack_i` is ignored.
- `wb_ack_i` is ignored outside FILL.

## Timing

- Request is sampled in IDLE at cycle N.
- Hit: `cpu_ack_o` in cycle N+1. Back-to-back hits give one ack every 2 cycles.
- Miss:
  - `wb_cyc_o` high from cycle N+2.
  - `wb_ack_i` at cycle M (M ≥ N+2) gives `cpu_ack_o` at M+1.
  - With a zero-wait slave, ack arrives at N+3.
- Bus outputs are registered. `cpu_ack_o` is combinational from state and hit, and never depends on `cpu_cyc_i` in the same cycle.
- `wb_cyc_o` deasserts in the cycle after `wb_ack_i`. There is exactly one bus beat per miss.

## Structure

- Add to `define.v`: `PcWidth` (13:0), `DataWidth`, `ICacheLines`, `InstNop` (32'h6000_0000), and the FSM state encodings (`IF_IDLE`, `IF_LOOKUP`, `IF_FILL`, `IF_RESP`, 2 bits).
- Sub-module `j1_icache_array`:
  - tag/data/valid storage with a combinational read port;
  - one synchronous write port;
  - global clear (`clr`, driven by `rst | flush_i`).
  - It has priority logic: clear beats write.
- The top level holds the FSM, `req_pc`, the output register and the Wishbone driving.

## Test plan

- Cold miss:
  - Stimulus: after reset, request pc=14'h1005; slave returns 32'h4123 with 1 wait state.
  - Expected: `wb_adr_o`=32'h0000_4014; one bus beat; `cpu_ack_o` one cycle after `wb_ack_i` with `cpu_inst_o`=32'h0000_4123.
- Hit:
  - Stimulus: re-request pc=14'h1005.
  - Expected: ack at N+1, `cpu_inst_o`=32'h0000_4123, `wb_cyc_o` never asserted.
- Conflict:
  - Stimulus: with LINES=16, request 14'h1015 (same index 5, different tag) with slave data 32'h7777.
  - Expected: miss, fill; a following 14'h1005 misses again.
- Flush during fill:
  - Stimulus: pulse `flush_i` in the `wb_ack_i` cycle of a 14'h2001 miss.
  - Expected: CPU still gets its ack and data; re-requesting 14'h2001 misses.
- Reset mid-FILL:
  - Stimulus: assert `rst` while `wb_cyc_o` is high; slave acks afterward.
  - Expected: `wb_cyc_o`=0 next cycle, no `cpu_ack_o`, `cpu_inst_o`=32'h6000_0000, all lines invalid.
- Back-to-back hits:
  - Stimulus: CPU presents 14'h1005 then 14'h1006 (both pre-filled) with `cpu_cyc_i` held high.
  - Expected: acks exactly every 2 cycles, each request acked once.

Source files
------------

// File: rtl/j1_inst_fetch_pkg.sv
// j1_inst_fetch_pkg
// Shared constants and FSM state encoding for the J1 instruction-fetch
// front end and its cache storage array.
package j1_inst_fetch_pkg;

   localparam int          PcWidth     = 14;             // word address width of the CPU PC
   localparam int          DataWidth   = 32;             // instruction word width
   localparam int          ICacheLines = 16;             // default number of cache lines
   localparam logic [31:0] InstNop     = 32'h6000_0000;  // ALU no-op instruction

   typedef enum logic [1:0] {
      IF_IDLE   = 2'd0,
      IF_LOOKUP = 2'd1,
      IF_FILL   = 2'd2,
      IF_RESP   = 2'd3
   } if_state_t;

endpackage

// File: rtl/j1_icache_array.sv
// j1_icache_array
// Direct-mapped tag/data/valid storage for the instruction cache.
// Ports:
//   clk      - clock
//   clr      - synchronous global clear of all valid bits (beats a write)
//   rd_idx   - read index; rd_valid/rd_tag/rd_data are combinational
//   wr_en    - write strobe; writes wr_tag/wr_data at wr_idx and sets valid
module j1_icache_array
   import j1_inst_fetch_pkg::*;
#(
   parameter int LINES = ICacheLines,
   parameter int IW    = $clog2(LINES),
   parameter int TW    = PcWidth - IW
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic [IW-1:0]        rd_idx,
   output logic                 rd_valid,
   output logic [TW-1:0]        rd_tag,
   output logic [DataWidth-1:0] rd_data,
   input  logic                 wr_en,
   input  logic [IW-1:0]        wr_idx,
   input  logic [TW-1:0]        wr_tag,
   input  logic [DataWidth-1:0] wr_data
);

   logic [TW-1:0]        tag_mem  [LINES];
   logic [DataWidth-1:0] data_mem [LINES];
   logic [LINES-1:0]     valid_reg;

   // Valid bits: clear has priority, so a flush coinciding with a fill
   // leaves that line invalid.
   generate
      for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
         always_ff @(posedge clk) begin
            if (clr)
               valid_reg[gi] <= 1'b0;
            else if (wr_en && (wr_idx == IW'(gi)))
               valid_reg[gi] <= 1'b1;
         end
      end
   endgenerate

   // Tag/data contents need no reset; the valid bit gates their use.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_idx]  <= wr_tag;
         data_mem[wr_idx] <= wr_data;
      end
   end

   assign rd_valid = valid_reg[rd_idx];
   assign rd_tag   = tag_mem[rd_idx];
   assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/j1_inst_fetch.sv
// j1_inst_fetch
// Instruction-fetch front end: serves CPU fetches from a direct-mapped
// one-word-per-line cache and fills misses with a single Wishbone
// classic read.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   cpu_cyc_i/cpu_pc_i  - fetch request and word address (held until ack)
//   cpu_inst_o          - fetched instruction, valid with ack and held after
//   cpu_ack_o           - one-cycle completion pulse
//   flush_i             - invalidate all cache lines
//   wb_*                - Wishbone classic master read port
module j1_inst_fetch
   import j1_inst_fetch_pkg::*;
#(
   parameter int          LINES     = ICacheLines,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cpu_cyc_i,
   input  logic [PcWidth-1:0]   cpu_pc_i,
   output logic [DataWidth-1:0] cpu_inst_o,
   output logic                 cpu_ack_o,
   input  logic                 flush_i,
   output logic                 wb_cyc_o,
   output logic                 wb_stb_o,
   output logic [31:0]          wb_adr_o,
   input  logic [DataWidth-1:0] wb_dat_i,
   input  logic                 wb_ack_i
);

   localparam int IW = $clog2(LINES);
   localparam int TW = PcWidth - IW;

   if_state_t            state_reg, state_next;
   logic [PcWidth-1:0]   req_pc_reg;
   logic [DataWidth-1:0] inst_reg;
   logic                 wb_cyc_reg;
   logic [31:0]          wb_adr_reg;

   logic                 line_valid;
   logic [TW-1:0]        line_tag;
   logic [DataWidth-1:0] line_data;
   logic                 hit;
   logic                 fill_we;
   logic                 ack;

   assign fill_we = (state_reg == IF_FILL) && wb_ack_i;

   j1_icache_array #(
      .LINES (LINES),
      .IW    (IW),
      .TW    (TW)
   ) u_array (
      .clk      (clk),
      .clr      (rst | flush_i),
      .rd_idx   (req_pc_reg[IW-1:0]),
      .rd_valid (line_valid),
      .rd_tag   (line_tag),
      .rd_data  (line_data),
      .wr_en    (fill_we),
      .wr_idx   (req_pc_reg[IW-1:0]),
      .wr_tag   (req_pc_reg[PcWidth-1:IW]),
      .wr_data  (wb_dat_i)
   );

   assign hit = line_valid && (line_tag == req_pc_reg[PcWidth-1:IW]);

   always_ff @(posedge clk) begin
      if (rst)
         state_reg <= IF_IDLE;
      else
         state_reg <= state_next;
   end

   // Ack depends only on state and the cache read, never on cpu_cyc_i.
   always_comb begin
      state_next = state_reg;
      ack        = 1'b0;
      case (state_reg)
         IF_IDLE: begin
            if (cpu_cyc_i)
               state_next = IF_LOOKUP;
         end
         IF_LOOKUP: begin
            if (hit) begin
               ack        = 1'b1;
               state_next = IF_IDLE;
            end else begin
               state_next = IF_FILL;
            end
         end
         IF_FILL: begin
            if (wb_ack_i)
               state_next = IF_RESP;
         end
         IF_RESP: begin
            ack        = 1'b1;
            state_next = IF_IDLE;
         end
         default: state_next = IF_IDLE;
      endcase
   end

   // Datapath registers. The bus address is computed when the request is
   // accepted so it is already stable when the cycle opens.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_pc_reg <= '0;
         inst_reg   <= InstNop;
         wb_cyc_reg <= 1'b0;
         wb_adr_reg <= BASE_ADDR;
      end else begin
         case (state_reg)
            IF_IDLE: begin
               if (cpu_cyc_i) begin
                  req_pc_reg <= cpu_pc_i;
                  wb_adr_reg <= BASE_ADDR + {16'b0, cpu_pc_i, 2'b00};
               end
            end
            IF_LOOKUP: begin
               if (hit)
                  inst_reg <= line_data;
               else
                  wb_cyc_reg <= 1'b1;
            end
            IF_FILL: begin
               if (wb_ack_i) begin
                  inst_reg   <= wb_dat_i;
                  wb_cyc_reg <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // On a hit the line data bypasses the output register in the ack cycle;
   // the register captures it at the same edge so the word stays held.
   assign cpu_inst_o = ((state_reg == IF_LOOKUP) && hit) ? line_data : inst_reg;
   assign cpu_ack_o  = ack;
   assign wb_cyc_o   = wb_cyc_reg;
   assign wb_stb_o   = wb_cyc_reg;
   assign wb_adr_o   = wb_adr_reg;

endmodule

// File: tb/tb_j1_inst_fetch.sv
// tb_j1_inst_fetch
// Directed, cycle-exact bench for j1_inst_fetch (LINES=16, BASE_ADDR=0).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_j1_inst_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_cyc_i;
   logic [13:0] cpu_pc_i;
   logic [31:0] cpu_inst_o;
   logic        cpu_ack_o;
   logic        flush_i;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   j1_inst_fetch #(
      .LINES     (16),
      .BASE_ADDR (32'h0000_0000)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_cyc_i  (cpu_cyc_i),
      .cpu_pc_i   (cpu_pc_i),
      .cpu_inst_o (cpu_inst_o),
      .cpu_ack_o  (cpu_ack_o),
      .flush_i    (flush_i),
      .wb_cyc_o   (wb_cyc_o),
      .wb_stb_o   (wb_stb_o),
      .wb_adr_o   (wb_adr_o),
      .wb_dat_i   (wb_dat_i),
      .wb_ack_i   (wb_ack_i)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Miss: LOOKUP, FILL (+waits), slave ack, RESP with the word.
   task automatic fetch_miss(input string tag, input logic [13:0] pc, input int waits,
                             input logic [31:0] data, input logic [31:0] adr, input logic flush);
      cpu_cyc_i = 1'b1;
      cpu_pc_i  = pc;
      tick();                                   // LOOKUP
      chk({tag, "_lookup_ack"}, {31'b0, cpu_ack_o}, 32'd0);
      chk({tag, "_lookup_cyc"}, {31'b0, wb_cyc_o}, 32'd0);
      tick();                                   // first FILL cycle
      chk({tag, "_fill_cyc"}, {31'b0, wb_cyc_o}, 32'd1);
      chk({tag, "_fill_stb"}, {31'b0, wb_stb_o}, 32'd1);
      chk({tag, "_fill_adr"}, wb_adr_o, adr);
      for (int i = 0; i < waits; i++) begin
         tick();
         chk({tag, "_wait_cyc"}, {31'b0, wb_cyc_o}, 32'd1);
         chk({tag, "_wait_ack"}, {31'b0, cpu_ack_o}, 32'd0);
      end
      wb_ack_i = 1'b1;
      wb_dat_i = data;
      flush_i  = flush;
      chk({tag, "_busack_cpuack"}, {31'b0, cpu_ack_o}, 32'd0);
      tick();                                   // RESP
      wb_ack_i = 1'b0;
      wb_dat_i = 32'hDEAD_BEEF;
      flush_i  = 1'b0;
      chk({tag, "_resp_ack"}, {31'b0, cpu_ack_o}, 32'd1);
      chk({tag, "_resp_inst"}, cpu_inst_o, data);
      chk({tag, "_resp_cyc"}, {31'b0, wb_cyc_o}, 32'd0);
      cpu_cyc_i = 1'b0;
      tick();
      chk({tag, "_after_ack"}, {31'b0, cpu_ack_o}, 32'd0);
      chk({tag, "_held_inst"}, cpu_inst_o, data);
   endtask

   task automatic fetch_hit(input string tag, input logic [13:0] pc, input logic [31:0] data);
      cpu_cyc_i = 1'b1;
      cpu_pc_i  = pc;
      tick();                                   // LOOKUP
      chk({tag, "_ack"}, {31'b0, cpu_ack_o}, 32'd1);
      chk({tag, "_inst"}, cpu_inst_o, data);
      chk({tag, "_cyc"}, {31'b0, wb_cyc_o}, 32'd0);
      cpu_cyc_i = 1'b0;
      tick();
      chk({tag, "_after_ack"}, {31'b0, cpu_ack_o}, 32'd0);
      chk({tag, "_held_inst"}, cpu_inst_o, data);
      chk({tag, "_after_cyc"}, {31'b0, wb_cyc_o}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      cpu_cyc_i = 1'b0;
      cpu_pc_i  = '0;
      flush_i   = 1'b0;
      wb_dat_i  = '0;
      wb_ack_i  = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_inst", cpu_inst_o, 32'h6000_0000);
      chk("rst_ack", {31'b0, cpu_ack_o}, 32'd0);
      chk("rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
      chk("rst_stb", {31'b0, wb_stb_o}, 32'd0);
      chk("rst_adr", wb_adr_o, 32'h0000_0000);
      tick();

      // Cold miss with one wait state, then a hit
      fetch_miss("cold", 14'h1005, 1, 32'h0000_4123, 32'h0000_4014, 1'b0);
      fetch_hit("hit", 14'h1005, 32'h0000_4123);

      // Conflict on index 5 evicts 1005
      fetch_miss("conf", 14'h1015, 0, 32'h0000_7777, 32'h0000_4054, 1'b0);
      fetch_hit("conf_hit", 14'h1015, 32'h0000_7777);
      fetch_miss("evicted", 14'h1005, 0, 32'h0000_4123, 32'h0000_4014, 1'b0);

      // Flush in the bus-ack cycle: data still delivered, line stays invalid
      fetch_miss("flfill", 14'h2001, 2, 32'h0000_ABCD, 32'h0000_8004, 1'b1);
      fetch_miss("flrefill", 14'h2001, 0, 32'h0000_ABCD, 32'h0000_8004, 1'b0);
      fetch_miss("flother", 14'h1005, 0, 32'h0000_4123, 32'h0000_4014, 1'b0);

      // Back-to-back hits with cpu_cyc_i held high
      fetch_miss("pre1006", 14'h1006, 0, 32'h0000_5555, 32'h0000_4018, 1'b0);
      cpu_cyc_i = 1'b1;
      cpu_pc_i  = 14'h1005;
      tick();
      chk("b2b_ack0", {31'b0, cpu_ack_o}, 32'd1);
      chk("b2b_inst0", cpu_inst_o, 32'h0000_4123);
      cpu_pc_i = 14'h1006;
      tick();
      chk("b2b_gap", {31'b0, cpu_ack_o}, 32'd0);
      tick();
      chk("b2b_ack1", {31'b0, cpu_ack_o}, 32'd1);
      chk("b2b_inst1", cpu_inst_o, 32'h0000_5555);
      cpu_cyc_i = 1'b0;
      tick();
      chk("b2b_tail0", {31'b0, cpu_ack_o}, 32'd0);
      tick();
      chk("b2b_tail1", {31'b0, cpu_ack_o}, 32'd0);
      chk("b2b_cyc", {31'b0, wb_cyc_o}, 32'd0);

      // Reset in the middle of a fill; a late slave ack is ignored
      cpu_cyc_i = 1'b1;
      cpu_pc_i  = 14'h1007;
      tick();
      tick();
      chk("rstfill_cyc", {31'b0, wb_cyc_o}, 32'd1);
      rst       = 1'b1;
      cpu_cyc_i = 1'b0;
      tick();
      rst = 1'b0;
      chk("rstfill_cyc_drop", {31'b0, wb_cyc_o}, 32'd0);
      chk("rstfill_ack", {31'b0, cpu_ack_o}, 32'd0);
      chk("rstfill_inst", cpu_inst_o, 32'h6000_0000);
      wb_ack_i = 1'b1;
      wb_dat_i = 32'h0000_DEAD;
      tick();
      wb_ack_i = 1'b0;
      chk("late_ack_cyc", {31'b0, wb_cyc_o}, 32'd0);
      chk("late_ack_cpuack", {31'b0, cpu_ack_o}, 32'd0);
      chk("late_ack_inst", cpu_inst_o, 32'h6000_0000);
      tick();
      chk("late_ack_idle", {31'b0, cpu_ack_o}, 32'd0);
      // All lines invalid after reset
      fetch_miss("postrst", 14'h1005, 0, 32'h0000_4123, 32'h0000_4014, 1'b0);
      fetch_miss("postrst2", 14'h1006, 0, 32'h0000_5555, 32'h0000_4018, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
